// File: rtl/pattern_transmitter.sv
// Serialises a 16-bit word (built-in PATTERN or caller word) MSB-first with a valid strobe,
// then presents the word on a registered parallel bus for one cycle. Option: PATGEN_PARITY_EN.
module pattern_transmitter #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] PATTERN = 16'hA5C3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_use_default,
  input  logic [WIDTH-1:0] i_pattern_in,
  output logic             o_tx_bit,
  output logic             o_tx_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_word_out,
  output logic             o_word_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef PATGEN_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd3
  } state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_tx_bit, w_tx_bit_nxt;
  logic             r_tx_valid, w_tx_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_word_out, w_word_out_nxt;
  logic             r_word_valid, w_word_valid_nxt;
  logic [WIDTH-1:0] w_word;

  assign w_word = i_use_default ? PATTERN : i_pattern_in;

  // Next-state and next-output logic; every output is computed one cycle ahead and registered.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_hold_nxt       = r_hold;
    w_cnt_nxt        = r_cnt;
    w_tx_bit_nxt     = 1'b0;
    w_tx_valid_nxt   = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_word_out_nxt   = r_word_out;
    w_word_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt    = ST_SHIFT;
          w_hold_nxt     = w_word;
          w_shift_nxt    = {w_word[WIDTH-2:0], 1'b0};
          w_cnt_nxt      = {CW{1'b0}};
          w_tx_bit_nxt   = w_word[WIDTH-1];
          w_tx_valid_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_busy_nxt = 1'b1;
        // r_cnt indexes the bit currently on the line; the last data bit ends the shift phase
        if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef PATGEN_PARITY_EN
          w_state_nxt    = ST_PARITY;
          w_tx_bit_nxt   = even_parity(r_hold);
          w_tx_valid_nxt = 1'b1;
`else
          w_state_nxt      = ST_DONE;
          w_done_nxt       = 1'b1;
          w_word_valid_nxt = 1'b1;
          w_word_out_nxt   = r_hold;
`endif
        end else begin
          w_tx_bit_nxt   = r_shift[WIDTH-1];
          w_tx_valid_nxt = 1'b1;
          w_shift_nxt    = {r_shift[WIDTH-2:0], 1'b0};
          w_cnt_nxt      = r_cnt + CW'(1);
        end
      end
`ifdef PATGEN_PARITY_EN
      ST_PARITY: begin
        w_state_nxt      = ST_DONE;
        w_busy_nxt       = 1'b1;
        w_done_nxt       = 1'b1;
        w_word_valid_nxt = 1'b1;
        w_word_out_nxt   = r_hold;
      end
`endif
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= {WIDTH{1'b0}};
      r_hold       <= {WIDTH{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_tx_bit     <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_out   <= {WIDTH{1'b0}};
      r_word_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_hold       <= w_hold_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tx_bit     <= w_tx_bit_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_word_out   <= w_word_out_nxt;
      r_word_valid <= w_word_valid_nxt;
    end
  end

  assign o_tx_bit     = r_tx_bit;
  assign o_tx_valid   = r_tx_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_word_out   = r_word_out;
  assign o_word_valid = r_word_valid;

endmodule

// File: doc/pattern_transmitter.md
Name: pattern_transmitter

Overview:
Transmit-side companion to the 16-bit pattern detector. Loads a 16-bit word (either the built-in target pattern or a caller-supplied word) and serialises it MSB-first, one bit per clk, with a valid strobe. At end of frame it presents the full word on a registered parallel bus for one cycle, so both serial and parallel detector inputs can be driven from one source. Sits upstream of the detector in the lab test harness.

Parameters:
WIDTH, 16, frame data width in bits; fixed at 16 for this block; counter sized $clog2(WIDTH)+1.
PATTERN, 16'hA5C3, built-in target word sent when use_default=1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
start  input  1  request a frame; sampled only in IDLE.
use_default  input  1  sampled with start; 1 = send PATTERN, 0 = send pattern_in.
pattern_in  input  16  caller word; sampled with start.
tx_bit  output  1  serial data, MSB first; 0 when tx_valid=0.
tx_valid  output  1  high on every cycle carrying a frame bit.
busy  output  1  high from first bit cycle through DONE cycle inclusive.
done  output  1  one-cycle pulse at end of frame.
word_out  output  16  last completed frame word; holds between frames.
word_valid  output  1  one-cycle pulse, coincident with done, qualifying word_out update.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift reg=0, bit count=0, tx_bit=0, tx_valid=0, busy=0, done=0, word_out=16'h0000, word_valid=0. Takes effect immediately, not at the next edge.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, SHIFT, (PARITY when PATGEN_PARITY_EN is defined), DONE.
- IDLE:
  - On start=1 at edge T, latch the word: PATTERN if use_default=1, else pattern_in. Latch the same word into a hold register. Clear bit count. Go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - Cycle T+1+k (k=0..15): tx_valid=1, busy=1, tx_bit = word[15-k].
  - After k=15, go to DONE, or to PARITY when PATGEN_PARITY_EN is defined.
- DONE, one cycle:
  - tx_valid=0, busy=1, done=1, word_valid=1, word_out=hold register.
  - Next state is IDLE.
- Latency: start at edge T gives first bit T+1, last bit T+16, done at T+17 (T+18 with parity).
- start is ignored in every non-IDLE state, including the DONE cycle. The earliest next start is the first IDLE cycle after DONE, so the minimum frame-to-frame spacing is 18 cycles.
- pattern_in and use_default changes mid-frame have no effect; the word is sampled at start only.
- Reset mid-frame aborts the frame: no done pulse, word_out returns to 0.
- word_out changes only in the DONE cycle or on reset.

Optional Feature:
PATGEN_PARITY_EN.
- Defined:
  - After bit 15, a PARITY state emits one extra bit with tx_valid=1, busy=1, tx_bit = even parity (XOR of the 16 data bits).
  - DONE follows the PARITY state.
  - Frame length is 17 bits; done occurs at T+18.
- Undefined: the PARITY state and its logic are absent; frame length is 16 bits.

Test Plan:
1. Reset, then start=1 with use_default=1 at edge T -> tx_valid high T+1..T+16, tx_bit = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; done=word_valid=1 at T+17 with word_out=16'hA5C3; busy low at T+18.
2. start with use_default=0, pattern_in=16'h0001 -> fifteen 0s then a 1 on bit 16; word_out=16'h0001 at done.
3. Mid-frame stimulus:
   - start pulses at bits 3 and 16, and during the DONE cycle -> all ignored; exactly one done pulse.
   - Change pattern_in to 16'hFFFF at bit 5 -> transmitted word unchanged.
4. Assert rst asynchronously (between edges) during bit 7 of a 16'hA5C3 frame -> all outputs 0 immediately; no done pulse; word_out=0; a new start after release sends a full clean frame.
5. Back-to-back: start held high continuously -> frames begin every 18 cycles; word_out alternates correctly when use_default toggles between frames (16'h1234 then 16'hA5C3).
6. With PATGEN_PARITY_EN defined:
   - 16'hA5C3 (8 ones) -> 17th bit = 0, done at T+18.
   - 16'h0001 -> 17th bit = 1.
